chop_gen_mc: RTL and testbench

Parametrised multi-channel chopper generator, successor to the single-channel chopper in the W7X interlock front end. One period counter drives N_CH chop outputs with per-channel polarity, a shared post-transition data-hold window for the integrators, and delay-compensated copies of the chop and hold signals. Period configuration is shadowed and applied only at period boundaries, and invalid settings are detected. An optional external sync aligns the period across boards.

---
 rtl/chop_gen_pkg.sv | 19 +
 rtl/chop_gen_mc_if.sv | 29 ++
 rtl/chop_dly_line.sv | 27 ++
 rtl/chop_gen_mc.sv | 158 +++++++++++++++
 tb/tb_chop_gen_mc.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/chop_gen_pkg.sv
// Shared constants for the multi-channel chopper: default geometry and FSM state encoding.
package chop_gen_pkg;

   localparam int N_CH_DEF         = 16;
   localparam int CNT_W_DEF        = 32;
   localparam int HOLD_SAMPLES_DEF = 3;
   localparam int OUT_DLY_DEF      = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      ARM  = ST_ARM,
      RUN  = ST_RUN
   } state_e;

endpackage

// File: rtl/chop_gen_mc_if.sv
// Control/status bundle of the chopper: run control and period settings in, chop/hold/status out.
interface chop_gen_mc_if
   import chop_gen_pkg::*;
#(
   parameter int N_CH  = N_CH_DEF,
   parameter int CNT_W = CNT_W_DEF
);
   logic             chop_en;
   logic             chop_default;
   logic [N_CH-1:0]  ch_invert;
   logic [CNT_W-1:0] change_count;
   logic [CNT_W-1:0] max_count;
   logic             sync_i;
   logic [N_CH-1:0]  chop_o;
   logic [N_CH-1:0]  chop_dly_o;
   logic             data_hold_o;
   logic             period_o;
   logic             cfg_err_o;

   modport master (
      output chop_en, chop_default, ch_invert, change_count, max_count, sync_i,
      input  chop_o, chop_dly_o, data_hold_o, period_o, cfg_err_o
   );

   modport slave (
      input  chop_en, chop_default, ch_invert, change_count, max_count, sync_i,
      output chop_o, chop_dly_o, data_hold_o, period_o, cfg_err_o
   );
endinterface

// File: rtl/chop_dly_line.sv
// Fixed-length shift register aligning chop and hold for the integrators; DEPTH=0 is a wire.
module chop_dly_line #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   if (DEPTH == 0) begin : g_pass
      assign q_o = d_i;
   end else begin : g_shift
      logic [WIDTH-1:0] tap_q [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
         end else begin
            tap_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
         end
      end

      assign q_o = tap_q[DEPTH-1];
   end
endmodule

// File: rtl/chop_gen_mc.sv
// Multi-channel chopper: shared period counter, per-channel polarity, post-transition hold window.
// Define CHOP_GEN_SYNC_EN to add the ARM state and external sync_i period alignment.
module chop_gen_mc
   import chop_gen_pkg::*;
#(
   parameter int N_CH         = N_CH_DEF,
   parameter int CNT_W        = CNT_W_DEF,
   parameter int HOLD_SAMPLES = HOLD_SAMPLES_DEF,
   parameter int OUT_DLY      = OUT_DLY_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   chop_gen_mc_if.slave  bus
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] chg_q, chg_d;
   logic [CNT_W-1:0] max_q, max_d;
   logic [N_CH-1:0]  chop_q, chop_d;
   logic             hold_q, hold_d;
   logic             period_q, period_d;
   logic             err_q, err_d;
   logic             first_q, first_d;
   logic             phase_b_d;
   logic             cfg_ok;
   logic             wrap;
   logic             sync_rise;
   logic [N_CH:0]    dly_out;

`ifdef CHOP_GEN_SYNC_EN
   localparam state_e START_ST = ARM;
   logic sync_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 1'b0;
      else          sync_q <= bus.sync_i;
   end

   assign sync_rise = bus.sync_i & ~sync_q;
`else
   localparam state_e START_ST = RUN;
   logic unused_sync;

   assign unused_sync = bus.sync_i;
   assign sync_rise   = 1'b0;
`endif

   // Validation always looks at the live inputs because it runs only at the moment they are latched.
   assign cfg_ok = (bus.max_count >= CNT_W'(2)) && (bus.change_count != '0) &&
                   (bus.change_count < bus.max_count);
   assign wrap   = (cnt_q == max_q - CNT_W'(1));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      chg_d     = chg_q;
      max_d     = max_q;
      err_d     = err_q;
      first_d   = first_q;
      period_d  = 1'b0;
      phase_b_d = 1'b0;
      hold_d    = 1'b0;

      if (!bus.chop_en) begin
         state_d = IDLE;
         cnt_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               chg_d = bus.change_count;
               max_d = bus.max_count;
               if (cfg_ok) begin
                  state_d = START_ST;
                  first_d = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
            ARM: begin
               if (sync_rise) begin
                  state_d = RUN;
                  cnt_d   = '0;
                  first_d = 1'b1;
               end
            end
            RUN: begin
               if (wrap || sync_rise) begin
                  cnt_d    = '0;
                  period_d = 1'b1;
                  chg_d    = bus.change_count;
                  max_d    = bus.max_count;
                  // A sync landing in phase A makes no B->A transition, so the hold is suppressed.
                  first_d  = sync_rise && (cnt_q < chg_q);
                  if (!cfg_ok) begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      if (state_d == RUN) begin
         phase_b_d = (cnt_d >= chg_d);
         hold_d    = (phase_b_d && (cnt_d < chg_d + CNT_W'(HOLD_SAMPLES))) ||
                     ((cnt_d < CNT_W'(HOLD_SAMPLES)) && !first_d);
      end
      chop_d = {N_CH{bus.chop_default ^ phase_b_d}} ^ bus.ch_invert;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         chg_q    <= '0;
         max_q    <= '0;
         chop_q   <= '0;
         hold_q   <= 1'b0;
         period_q <= 1'b0;
         err_q    <= 1'b0;
         first_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         chg_q    <= chg_d;
         max_q    <= max_d;
         chop_q   <= chop_d;
         hold_q   <= hold_d;
         period_q <= period_d;
         err_q    <= err_d;
         first_q  <= first_d;
      end
   end

   chop_dly_line #(
      .WIDTH (N_CH + 1),
      .DEPTH (OUT_DLY)
   ) u_dly (
      .clk     (clk),
      .reset_n (reset_n),
      .d_i     ({hold_q, chop_q}),
      .q_o     (dly_out)
   );

   assign bus.chop_o      = chop_q;
   assign bus.chop_dly_o  = dly_out[N_CH-1:0];
   assign bus.data_hold_o = dly_out[N_CH];
   assign bus.period_o    = period_q;
   assign bus.cfg_err_o   = err_q;
endmodule

// File: tb/tb_chop_gen_mc.sv
// Directed bench for chop_gen_mc: period shape, delay alignment, shadowing, bad config, reset.
// With CHOP_GEN_SYNC_EN defined it also exercises the ARM wait and an in-run sync.
module tb_chop_gen_mc;
   import chop_gen_pkg::*;

   localparam int N_CH  = 16;
   localparam int CNT_W = 32;
   localparam int HOLD  = 3;
   localparam int DLY   = 3;

   logic clk = 1'b0;
   logic reset_n;
   int   vec_cnt = 0;
   int   err_cnt = 0;

   logic [N_CH-1:0] ph_a, ph_b;
   logic [0:47]     pat_b, pat_hold, pat_per;

   chop_gen_mc_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   chop_gen_mc #(
      .N_CH         (N_CH),
      .CNT_W        (CNT_W),
      .HOLD_SAMPLES (HOLD),
      .OUT_DLY      (DLY)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Leaves the bench sampling the first RUN cycle (cnt=0).
   task automatic start_run();
      bus.chop_en = 1'b1;
      tick();
`ifdef CHOP_GEN_SYNC_EN
      repeat (6) tick();
      chk("arm no toggle", 64'(bus.chop_o), 64'(ph_a));
      chk("arm no period", 64'(bus.period_o), 64'd0);
      bus.sync_i = 1'b1;
      tick();
      bus.sync_i = 1'b0;
`endif
   endtask

   initial begin
      reset_n          = 1'b0;
      bus.chop_en      = 1'b0;
      bus.chop_default = 1'b0;
      bus.ch_invert    = 16'h0001;
      bus.change_count = 32'd5;
      bus.max_count    = 32'd12;
      bus.sync_i       = 1'b0;
      ph_a             = 16'h0001;
      ph_b             = 16'hFFFE;
      pat_b    = 48'b000001111111_000001111111_000001111111_000000001111;
      pat_hold = 48'b000001110000_111001110000_111001110000_111000001110;
      pat_per  = 48'b000000000000_100000000000_100000000000_100000000000;

      tick();
      tick();
      chk("rst chop", 64'(bus.chop_o), 64'd0);
      chk("rst dly", 64'(bus.chop_dly_o), 64'd0);
      chk("rst hold", 64'(bus.data_hold_o), 64'd0);
      chk("rst period", 64'(bus.period_o), 64'd0);
      chk("rst err", 64'(bus.cfg_err_o), 64'd0);

      reset_n = 1'b1;
      tick();
      chk("idle chop", 64'(bus.chop_o), 64'(ph_a));
      tick();
      tick();

      // Basic period, then change_count rewritten mid-period at cnt=3 of the third period.
      start_run();
      for (int k = 0; k < 48; k++) begin
         if (k > 0) tick();
         chk($sformatf("chop k%0d", k), 64'(bus.chop_o), 64'(pat_b[k] ? ph_b : ph_a));
         chk($sformatf("period k%0d", k), 64'(bus.period_o), 64'(pat_per[k]));
         if (k >= DLY) begin
            chk($sformatf("dly k%0d", k), 64'(bus.chop_dly_o), 64'(pat_b[k-DLY] ? ph_b : ph_a));
            chk($sformatf("hold k%0d", k), 64'(bus.data_hold_o), 64'(pat_hold[k-DLY]));
         end else begin
            chk($sformatf("dly k%0d", k), 64'(bus.chop_dly_o), 64'(ph_a));
            chk($sformatf("hold k%0d", k), 64'(bus.data_hold_o), 64'd0);
         end
         if (k == 27) bus.change_count = 32'd8;
      end
      chk("run err", 64'(bus.cfg_err_o), 64'd0);

      // Asynchronous reset in the middle of a period.
      repeat (8) tick();
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst chop", 64'(bus.chop_o), 64'd0);
      chk("arst dly", 64'(bus.chop_dly_o), 64'd0);
      chk("arst hold", 64'(bus.data_hold_o), 64'd0);
      chk("arst period", 64'(bus.period_o), 64'd0);
      bus.chop_en = 1'b0;
      tick();
      chk("arst held", 64'(bus.chop_o), 64'd0);
      reset_n = 1'b1;
      tick();
      chk("rel chop", 64'(bus.chop_o), 64'(ph_a));
      chk("rel period", 64'(bus.period_o), 64'd0);

      // Invalid settings keep the block idle and flag a sticky error.
      bus.change_count = 32'd12;
      bus.max_count    = 32'd12;
      bus.chop_en      = 1'b1;
      tick();
      chk("bad err", 64'(bus.cfg_err_o), 64'd1);
      chk("bad chop", 64'(bus.chop_o), 64'(ph_a));
      repeat (6) tick();
      chk("bad still idle", 64'(bus.chop_o), 64'(ph_a));
      chk("bad period", 64'(bus.period_o), 64'd0);
      chk("bad sticky", 64'(bus.cfg_err_o), 64'd1);
      bus.chop_en = 1'b0;
      tick();
      chk("bad clr", 64'(bus.cfg_err_o), 64'd0);
      bus.change_count = 32'd0;
      bus.chop_en      = 1'b1;
      tick();
      chk("zero chg err", 64'(bus.cfg_err_o), 64'd1);
      bus.chop_en = 1'b0;
      tick();
      chk("zero chg clr", 64'(bus.cfg_err_o), 64'd0);

      // Inverted default level and a two-channel polarity mask, then drop enable in phase B.
      bus.chop_default = 1'b1;
      bus.ch_invert    = 16'h8001;
      bus.change_count = 32'd4;
      bus.max_count    = 32'd8;
      ph_a             = 16'h7FFE;
      ph_b             = 16'h8001;
      tick();
      start_run();
      for (int k = 0; k < 9; k++) begin
         if (k > 0) tick();
         chk($sformatf("inv chop k%0d", k), 64'(bus.chop_o), 64'(((k % 8) >= 4) ? ph_b : ph_a));
         chk($sformatf("inv period k%0d", k), 64'(bus.period_o), 64'(k == 8));
      end
      repeat (5) tick();
      chk("inv cnt5 B", 64'(bus.chop_o), 64'(ph_b));
      bus.chop_en = 1'b0;
      tick();
      chk("dis chop", 64'(bus.chop_o), 64'(ph_a));
      chk("dis period", 64'(bus.period_o), 64'd0);

`ifdef CHOP_GEN_SYNC_EN
      // Sync arriving at cnt=9 (phase B) restarts the period with a hold window.
      bus.chop_default = 1'b0;
      bus.ch_invert    = 16'h0001;
      bus.change_count = 32'd5;
      bus.max_count    = 32'd12;
      ph_a             = 16'h0001;
      ph_b             = 16'hFFFE;
      tick();
      start_run();
      repeat (9) tick();
      chk("sync pre B", 64'(bus.chop_o), 64'(ph_b));
      bus.sync_i = 1'b1;
      tick();
      bus.sync_i = 1'b0;
      chk("sync period", 64'(bus.period_o), 64'd1);
      chk("sync chop A", 64'(bus.chop_o), 64'(ph_a));
      tick();
      chk("sync period drop", 64'(bus.period_o), 64'd0);
      tick();
      for (int s = 3; s < 7; s++) begin
         tick();
         chk($sformatf("sync hold s%0d", s), 64'(bus.data_hold_o), 64'(s < 6));
      end
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
